// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: bundle of control, operand and status signals between
// the multiplier sequencer and its environment/datapath.
//   start, mp_in, mc_in, abort       : operation request from the host
//   zero_flag, b0                    : status from the shift-add datapath
//   dp_clr, load, enable, Psel       : datapath strobes
//   MP, MC                           : held operands to the datapath
//   busy, done, iter_cnt             : sequencer status
// master = host/datapath side, slave = sequencer side.
interface mul_seq_ctrl_if;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned CNT_W = 4;

    logic             start;
    logic [OP_W-1:0]  mp_in;
    logic [OP_W-1:0]  mc_in;
    logic             abort;
    logic             zero_flag;
    logic             b0;
    logic             dp_clr;
    logic             load;
    logic             enable;
    logic             Psel;
    logic [OP_W-1:0]  MP;
    logic [OP_W-1:0]  MC;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output start, mp_in, mc_in, abort, zero_flag, b0,
        input  dp_clr, load, enable, Psel, MP, MC, busy, done, iter_cnt
    );

    modport slave (
        input  start, mp_in, mc_in, abort, zero_flag, b0,
        output dp_clr, load, enable, Psel, MP, MC, busy, done, iter_cnt
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer for an 8x8 shift-add multiplier datapath.
// Walks IDLE -> CLEAR -> LOAD -> RUN (8 enable cycles) -> DONE, holding
// the captured operands for the datapath and counting enable cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mul_seq_ctrl_if.slave (request, datapath strobes, status)
// Optional feature: define MUL_EARLY_TERM_EN to end RUN as soon as the
// datapath multiplier shift register reads zero.
module mul_seq_ctrl (
    input  logic          clk,
    input  logic          rst,
    mul_seq_ctrl_if.slave bus
);
    localparam int unsigned OP_W    = 8;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(8);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept_c;
    logic             en_c;
    logic             term_c;

    logic [OP_W-1:0]  mp_q;
    logic [OP_W-1:0]  mc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clr_q;
    logic             load_q;
    logic             run_q;
    logic             busy_q;
    logic             done_q;

    // Shift/accumulate strobe; optionally suppressed once the multiplier is exhausted.
`ifdef MUL_EARLY_TERM_EN
    assign en_c   = run_q & ~bus.zero_flag;
    assign term_c = bus.zero_flag;
`else
    logic unused_zero_flag;
    assign unused_zero_flag = bus.zero_flag;
    assign en_c   = run_q;
    assign term_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort beats every other transition in busy states.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CLEAR;
                    accept_c = 1'b1;
                end
            end
            CLEAR: state_d = bus.abort ? IDLE : LOAD;
            LOAD:  state_d = bus.abort ? IDLE : RUN;
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (term_c || (en_c && (cnt_q >= CNT_LAST))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered state decodes, so each strobe mirrors the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q  <= 1'b0;
            load_q <= 1'b0;
            run_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            clr_q  <= (state_d == CLEAR);
            load_q <= (state_d == LOAD);
            run_q  <= (state_d == RUN);
            busy_q <= (state_d == CLEAR) || (state_d == LOAD) || (state_d == RUN);
            done_q <= (state_d == DONE);
        end
    end

    // Operand capture and saturating enable-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mp_q  <= '0;
            mc_q  <= '0;
            cnt_q <= '0;
        end else if (accept_c) begin
            mp_q  <= bus.mp_in;
            mc_q  <= bus.mc_in;
            cnt_q <= '0;
        end else if (en_c && (cnt_q < CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.dp_clr   = clr_q;
    assign bus.load     = load_q;
    assign bus.enable   = en_c;
    assign bus.Psel     = en_c & bus.b0;
    assign bus.MP       = mp_q;
    assign bus.MC       = mc_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.iter_cnt = cnt_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed bench for mul_seq_ctrl with a shift-add
// datapath model closing the zero_flag/b0 loop.
module tb_mul_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_seq_ctrl_if bus ();

    mul_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-add datapath: accumulator, shifted multiplicand, multiplier shift register.
    logic [15:0] acc;
    logic [15:0] mpr;
    logic [7:0]  sr;

    always @(posedge clk) begin
        if (bus.dp_clr) begin
            acc <= '0;
            mpr <= '0;
            sr  <= '0;
        end else if (bus.load) begin
            mpr <= {8'h00, bus.MP};
            sr  <= bus.MC;
        end else if (bus.enable) begin
            if (bus.Psel) acc <= acc + mpr;
            mpr <= mpr << 1;
            sr  <= sr >> 1;
        end
    end

    assign bus.zero_flag = (sr == 8'h00);
    assign bus.b0        = sr[0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dp_clr"}, 32'(bus.dp_clr), 32'd0);
        check({tag, "_load"},   32'(bus.load),   32'd0);
        check({tag, "_enable"}, 32'(bus.enable), 32'd0);
        check({tag, "_psel"},   32'(bus.Psel),   32'd0);
        check({tag, "_mp"},     32'(bus.MP),     32'd0);
        check({tag, "_mc"},     32'(bus.MC),     32'd0);
        check({tag, "_busy"},   32'(bus.busy),   32'd0);
        check({tag, "_done"},   32'(bus.done),   32'd0);
        check({tag, "_iter"},   32'(bus.iter_cnt), 32'd0);
    endtask

    // One full operation from IDLE; prod_exp is the hand-computed product.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int unsigned prod_exp);
        int n;
        n = 8;
`ifdef MUL_EARLY_TERM_EN
        n = 0;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`endif
        bus.start = 1'b1;
        bus.mp_in = a;
        bus.mc_in = b;
        step();
        bus.start = 1'b0;
        bus.mp_in = ~a;
        bus.mc_in = ~b;
        check({tag, "_clr"},      32'(bus.dp_clr), 32'd1);
        check({tag, "_clr_busy"}, 32'(bus.busy),   32'd1);
        check({tag, "_clr_load"}, 32'(bus.load),   32'd0);
        check({tag, "_mp"},       32'(bus.MP),     32'(a));
        check({tag, "_mc"},       32'(bus.MC),     32'(b));
        check({tag, "_iter0"},    32'(bus.iter_cnt), 32'd0);
        step();
        check({tag, "_load"},     32'(bus.load),   32'd1);
        check({tag, "_load_clr"}, 32'(bus.dp_clr), 32'd0);
        check({tag, "_load_en"},  32'(bus.enable), 32'd0);
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, "_run_en"},   32'(bus.enable),   32'd1);
            check({tag, "_run_psel"}, 32'(bus.Psel),     32'(b[i]));
            check({tag, "_run_iter"}, 32'(bus.iter_cnt), 32'(i));
            check({tag, "_run_busy"}, 32'(bus.busy),     32'd1);
        end
        if (n < 8) begin
            step();
            check({tag, "_term_en"},   32'(bus.enable), 32'd0);
            check({tag, "_term_busy"}, 32'(bus.busy),   32'd1);
        end
        step();
        check({tag, "_done"},      32'(bus.done),     32'd1);
        check({tag, "_done_busy"}, 32'(bus.busy),     32'd0);
        check({tag, "_done_iter"}, 32'(bus.iter_cnt), 32'(n));
        check({tag, "_prod"},      32'(acc),          32'(prod_exp));
        step();
        check({tag, "_done_off"},  32'(bus.done),     32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy),     32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.mp_in = 8'd33;
        bus.mc_in = 8'd44;
        step();
        step();
        check_zero("reset");
        bus.start = 1'b0;
        rst       = 1'b0;
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);

        run_op("op13x11", 8'd13, 8'd11, 143);
        run_op("op255x255", 8'd255, 8'd255, 65025);
        run_op("op5x0", 8'd5, 8'd0, 0);
        run_op("op5x1", 8'd5, 8'd1, 5);

        // start held high: back-to-back operations, operands frozen while busy.
        bus.start = 1'b1;
        bus.mp_in = 8'd13;
        bus.mc_in = 8'h8B;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 1) begin
                bus.mp_in = 8'd200;
                bus.mc_in = 8'h95;
            end
            check("b2b_clr",  32'(bus.dp_clr), 32'((k == 1) || (k == 13) || (k == 25)));
            check("b2b_done", 32'(bus.done),   32'((k == 11) || (k == 23)));
            check("b2b_mp",   32'(bus.MP),     (k < 13) ? 32'd13 : 32'd200);
            check("b2b_mc",   32'(bus.MC),     (k < 13) ? 32'h8B : 32'h95);
            if (k == 11) check("b2b_prod1", 32'(acc), 32'd1807);
            if (k == 23) check("b2b_prod2", 32'(acc), 32'd29800);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("b2b_rst");

        // Abort ignored in IDLE, honoured in CLEAR.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.mp_in = 8'd3;
        bus.mc_in = 8'd4;
        step();
        check("abort_idle_clr", 32'(bus.dp_clr), 32'd1);
        step();
        check("abort_clr_busy", 32'(bus.busy), 32'd0);
        check("abort_clr_load", 32'(bus.load), 32'd0);
        bus.abort = 1'b0;
        bus.start = 1'b0;

        // Abort in RUN at iter_cnt=3.
        bus.start = 1'b1;
        bus.mp_in = 8'd6;
        bus.mc_in = 8'hA5;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("abort_run_iter", 32'(bus.iter_cnt), 32'd3);
        check("abort_run_en",   32'(bus.enable),   32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy),   32'd0);
        check("abort_en",   32'(bus.enable), 32'd0);
        check("abort_done", 32'(bus.done),   32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        run_op("post_abort", 8'd6, 8'hA5, 990);

        // Reset mid-RUN.
        bus.start = 1'b1;
        bus.mp_in = 8'd9;
        bus.mc_in = 8'h87;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("rst_run_iter", 32'(bus.iter_cnt), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("rst_run");
        step();
        check("rst_no_done", 32'(bus.done), 32'd0);
        run_op("post_rst", 8'd7, 8'd9, 63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
